// File: rtl/inst_mem_loader.sv
// Program-image loader: assembles a little-endian byte stream into words and
// writes them to instruction memory while holding the core in reset.
module inst_mem_loader #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  input  logic                  abort_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_i,
  output logic                  byte_ready_o,
  output logic                  mem_we_o,
  output logic [31:0]           mem_waddr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  cpu_hold_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int LANES  = DATA_WIDTH / 8;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [LANE_W-1:0]   LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [LANE_W-1:0]   LANE_ONE  = LANE_W'(1);
  localparam logic [ADDR_WIDTH:0] IDX_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0] LEN_MAX   = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   word_idx;
  logic [ADDR_WIDTH:0]   word_idx_next;
  logic [LANE_W-1:0]     byte_cnt;
  logic [DATA_WIDTH-1:0] asm_q;
  logic [DATA_WIDTH-1:0] asm_merged;

  // Current partial word with the incoming byte dropped into its lane, so the
  // final byte can go straight into the write-data register.
  always_comb begin
    asm_merged = asm_q;
    asm_merged[8*int'(byte_cnt) +: 8] = byte_i;
  end

  assign word_idx_next = word_idx + IDX_ONE;

  // Outputs are registered alongside the state so each one always reflects the
  // state being entered; that keeps them glitch-free and Moore-timed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      len_q        <= '0;
      word_idx     <= '0;
      byte_cnt     <= '0;
      asm_q        <= '0;
      byte_ready_o <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_waddr_o  <= '0;
      mem_wdata_o  <= '0;
      cpu_hold_o   <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      mem_we_o <= 1'b0;
      done_o   <= 1'b0;

      case (state)
        IDLE: begin
          if (start_i) begin
            len_q    <= (len_i > LEN_MAX) ? LEN_MAX : len_i;
            word_idx <= '0;
            byte_cnt <= '0;
            busy_o   <= 1'b1;
            if (len_i == '0) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state        <= LOAD;
              byte_ready_o <= 1'b1;
              cpu_hold_o   <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (abort_i) begin
            state        <= IDLE;
            byte_cnt     <= '0;
            byte_ready_o <= 1'b0;
            cpu_hold_o   <= 1'b0;
            busy_o       <= 1'b0;
          end else if (byte_valid_i) begin
            asm_q    <= asm_merged;
            byte_cnt <= byte_cnt + LANE_ONE;
            if (byte_cnt == LAST_LANE) begin
              state        <= WRITE;
              byte_ready_o <= 1'b0;
              mem_we_o     <= 1'b1;
              mem_waddr_o  <= BASE_ADDR + (32'(word_idx) << 2);
              mem_wdata_o  <= asm_merged;
            end
          end
        end

        WRITE: begin
          word_idx <= word_idx_next;
          byte_cnt <= '0;
          if (abort_i) begin
            state      <= IDLE;
            cpu_hold_o <= 1'b0;
            busy_o     <= 1'b0;
          end else if (word_idx_next == len_q) begin
            state      <= DONE;
            cpu_hold_o <= 1'b0;
            done_o     <= 1'b1;
          end else begin
            state        <= LOAD;
            byte_ready_o <= 1'b1;
          end
        end

        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end

        default: begin
          state        <= IDLE;
          byte_ready_o <= 1'b0;
          cpu_hold_o   <= 1'b0;
          busy_o       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: directed and randomized loads compared
// against a byte-list reference model of the expected memory writes and timing.
module tb_inst_mem_loader;

  localparam int          ADDR_WIDTH = 10;
  localparam int          DATA_WIDTH = 32;
  localparam logic [31:0] BASE_ADDR  = 32'h0000_0000;
  localparam int          MAX_WORDS  = 1 << ADDR_WIDTH;

  logic                  clk;
  logic                  rst_n;
  logic                  start_i;
  logic [ADDR_WIDTH:0]   len_i;
  logic                  abort_i;
  logic                  byte_valid_i;
  logic [7:0]            byte_i;
  logic                  byte_ready_o;
  logic                  mem_we_o;
  logic [31:0]           mem_waddr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  cpu_hold_o;
  logic                  busy_o;
  logic                  done_o;

  inst_mem_loader #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .len_i       (len_i),
    .abort_i     (abort_i),
    .byte_valid_i(byte_valid_i),
    .byte_i      (byte_i),
    .byte_ready_o(byte_ready_o),
    .mem_we_o    (mem_we_o),
    .mem_waddr_o (mem_waddr_o),
    .mem_wdata_o (mem_wdata_o),
    .cpu_hold_o  (cpu_hold_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  int nVectors     = 0;
  int nMiscompares = 0;
  int cycle        = 0;
  int holdCount    = 0;

  logic [7:0]  imgBytes[$];
  logic [31:0] wrAddr[$];
  logic [31:0] wrData[$];
  int          wrCycle[$];
  int          doneCycle[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Observed activity, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (mem_we_o) begin
      wrAddr.push_back(mem_waddr_o);
      wrData.push_back(mem_wdata_o);
      wrCycle.push_back(cycle);
    end
    if (done_o) doneCycle.push_back(cycle);
    if (cpu_hold_o) holdCount++;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] global time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    nVectors++;
    assert (observed === expected)
    else begin
      nMiscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int clampLen(input int len);
    return (len > MAX_WORDS) ? MAX_WORDS : len;
  endfunction

  task automatic pushWord(input logic [31:0] w);
    for (int b = 0; b < 4; b++) imgBytes.push_back(w[8*b +: 8]);
  endtask

  task automatic fillRandom(input int nWords);
    imgBytes = {};
    for (int i = 0; i < 4 * nWords; i++) imgBytes.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic clearObserved();
    wrAddr    = {};
    wrData    = {};
    wrCycle   = {};
    doneCycle = {};
    holdCount = 0;
  endtask

  // gapMode: 0 continuous, 1 valid every other cycle, 2 random gaps.
  task automatic applyStimulus(input int len, input int gapMode, input int abortAfter,
                               input int startPulseAt, output int startCyc);
    int  idx;
    int  budget;
    int  nBytes;
    bit  give;
    bit  acc;
    nBytes = (abortAfter >= 0) ? abortAfter : imgBytes.size();
    @(posedge clk); #1;
    clearObserved();
    start_i  = 1'b1;
    len_i    = (ADDR_WIDTH + 1)'(len);
    startCyc = cycle;
    @(posedge clk); #1;
    start_i = 1'b0;
    idx     = 0;
    budget  = 0;
    while (idx < nBytes && budget <= 20 * nBytes + 100) begin
      give = (gapMode == 0) || (gapMode == 1 && budget % 2 == 0) ||
             (gapMode == 2 && $urandom_range(0, 2) != 0);
      byte_valid_i = give;
      byte_i       = give ? imgBytes[idx] : 8'($urandom_range(0, 255));
      start_i      = (startPulseAt >= 0 && idx == startPulseAt);
      if (start_i) len_i = (ADDR_WIDTH + 1)'($urandom_range(1, 5));
      @(negedge clk);
      acc = give && byte_ready_o;
      @(posedge clk); #1;
      if (acc) idx++;
      budget++;
    end
    checkOutput("byte_feed_timeout", 64'(idx < nBytes), 64'd0);
    byte_valid_i = 1'b0;
    start_i      = 1'b0;
    if (abortAfter >= 0) begin
      abort_i = 1'b1;
      @(posedge clk); #1;
      abort_i = 1'b0;
      checkOutput("abort_busy", 64'(busy_o), 64'd0);
      checkOutput("abort_hold", 64'(cpu_hold_o), 64'd0);
      checkOutput("abort_ready", 64'(byte_ready_o), 64'd0);
    end
    budget = 0;
    while (busy_o && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    checkOutput("idle_timeout", 64'(busy_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Reference: word k is bytes 4k..4k+3 little-endian at BASE+4k; with no gaps,
  // word k lands at start+5k+5, done at start+5N+1, hold high for 5N cycles.
  task automatic checkLoad(input string tag, input int expWords, input bit timed,
                           input int startCyc, input bit expDone);
    logic [31:0] expWord;
    checkOutput({tag, "_write_count"}, 64'(wrAddr.size()), 64'(expWords));
    for (int k = 0; k < expWords && k < wrAddr.size(); k++) begin
      expWord = {imgBytes[4*k+3], imgBytes[4*k+2], imgBytes[4*k+1], imgBytes[4*k]};
      checkOutput($sformatf("%s_addr[%0d]", tag, k), 64'(wrAddr[k]), 64'(BASE_ADDR + 32'(4 * k)));
      checkOutput($sformatf("%s_data[%0d]", tag, k), 64'(wrData[k]), 64'(expWord));
      if (timed)
        checkOutput($sformatf("%s_wcycle[%0d]", tag, k), 64'(wrCycle[k]), 64'(startCyc + 5 * k + 5));
    end
    checkOutput({tag, "_done_count"}, 64'(doneCycle.size()), 64'(expDone ? 1 : 0));
    if (timed && expDone) begin
      if (doneCycle.size() > 0)
        checkOutput({tag, "_done_cycle"}, 64'(doneCycle[0]), 64'(startCyc + 5 * expWords + 1));
      checkOutput({tag, "_hold_cycles"}, 64'(holdCount), 64'(5 * expWords));
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ready"}, 64'(byte_ready_o), 64'd0);
    checkOutput({tag, "_we"}, 64'(mem_we_o), 64'd0);
    checkOutput({tag, "_waddr"}, 64'(mem_waddr_o), 64'd0);
    checkOutput({tag, "_wdata"}, 64'(mem_wdata_o), 64'd0);
    checkOutput({tag, "_hold"}, 64'(cpu_hold_o), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy_o), 64'd0);
    checkOutput({tag, "_done"}, 64'(done_o), 64'd0);
  endtask

  initial begin
    int startCyc;
    int len;
    int nW;

    rst_n        = 1'b0;
    start_i      = 1'b0;
    len_i        = '0;
    abort_i      = 1'b0;
    byte_valid_i = 1'b0;
    byte_i       = '0;
    #12;
    checkAllZero("reset");
    #5 rst_n = 1'b1;

    $display("[TB] single word");
    imgBytes = {};
    pushWord(32'h0000_0013);
    applyStimulus(1, 0, -1, -1, startCyc);
    checkLoad("single", 1, 1'b1, startCyc, 1'b1);

    $display("[TB] multi-word with alternating gaps");
    imgBytes = {};
    pushWord(32'h0050_0093);
    pushWord(32'h0010_0113);
    pushWord(32'hFFDF_F06F);
    applyStimulus(3, 1, -1, -1, startCyc);
    checkLoad("gaps", 3, 1'b0, startCyc, 1'b1);

    $display("[TB] zero length");
    imgBytes = {};
    applyStimulus(0, 0, -1, -1, startCyc);
    checkLoad("zero", 0, 1'b1, startCyc, 1'b1);
    checkOutput("zero_hold_cycles", 64'(holdCount), 64'd0);

    $display("[TB] abort after two bytes, then fresh single-word load");
    fillRandom(2);
    applyStimulus(2, 0, 2, -1, startCyc);
    checkLoad("abort", 0, 1'b0, startCyc, 1'b0);
    fillRandom(1);
    applyStimulus(1, 0, -1, -1, startCyc);
    checkLoad("post_abort", 1, 1'b1, startCyc, 1'b1);

    $display("[TB] randomized loads");
    for (int i = 0; i < 6; i++) begin
      len = $urandom_range(1, 24);
      fillRandom(len);
      applyStimulus(len, i % 3, -1, -1, startCyc);
      checkLoad($sformatf("rand%0d", i), len, (i % 3) == 0, startCyc, 1'b1);
    end

    $display("[TB] random abort mid-word");
    nW = $urandom_range(2, 6);
    fillRandom(nW);
    len = 4 * $urandom_range(0, nW - 1) + $urandom_range(1, 3);
    applyStimulus(nW, 2, len, -1, startCyc);
    checkLoad("rand_abort", len / 4, 1'b0, startCyc, 1'b0);

    $display("[TB] full region with ignored start");
    fillRandom(MAX_WORDS);
    applyStimulus(MAX_WORDS, 0, -1, 300, startCyc);
    checkLoad("full", MAX_WORDS, 1'b1, startCyc, 1'b1);
    if (wrAddr.size() > 0)
      checkOutput("full_last_addr", 64'(wrAddr[wrAddr.size()-1]), 64'(BASE_ADDR + 32'hFFC));

    $display("[TB] oversize length clamps");
    len = 1500;
    fillRandom(clampLen(len));
    applyStimulus(len, 0, -1, -1, startCyc);
    checkLoad("clamp", clampLen(len), 1'b1, startCyc, 1'b1);

    $display("[TB] reset during load");
    imgBytes = {};
    pushWord(32'hA5A5_5A5A);
    pushWord(32'h1234_5678);
    @(posedge clk); #1;
    start_i = 1'b1;
    len_i   = (ADDR_WIDTH + 1)'(2);
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      byte_valid_i = 1'b1;
      byte_i       = imgBytes[b];
      @(posedge clk); #1;
    end
    byte_valid_i = 1'b0;
    checkOutput("pre_reset_hold", 64'(cpu_hold_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkAllZero("async_reset");
    #3 rst_n = 1'b1;
    clearObserved();
    byte_valid_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      byte_i = 8'($urandom_range(0, 255));
      @(negedge clk);
      checkOutput($sformatf("post_reset_ready[%0d]", c), 64'(byte_ready_o), 64'd0);
      checkOutput($sformatf("post_reset_busy[%0d]", c), 64'(busy_o), 64'd0);
    end
    byte_valid_i = 1'b0;
    checkOutput("post_reset_writes", 64'(wrAddr.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
